// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and fetch constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: pc, pc+4, instruction and valid.
// Latency: one cycle from load to outputs.
// Backpressure: i_hold freezes every field; i_bubble overrides load and hold.
module ifid_reg
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_bubble,
   input  logic              i_hold,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_pc_plus4,
   input  logic [INST_W-1:0] i_inst,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_pc_plus4,
   output logic [INST_W-1:0] o_inst,
   output logic              o_valid
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pc_plus4;
   logic [INST_W-1:0] r_inst;
   logic              r_valid;

   // A bubble uses the same field values as reset so ID sees an identical NOP.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc       <= '0;
         r_pc_plus4 <= '0;
         r_inst     <= INST_W'(NOP_INST);
         r_valid    <= 1'b0;
      end else if (i_bubble) begin
         r_pc       <= '0;
         r_pc_plus4 <= '0;
         r_inst     <= INST_W'(NOP_INST);
         r_valid    <= 1'b0;
      end else if (i_load && !i_hold) begin
         r_pc       <= i_pc;
         r_pc_plus4 <= i_pc_plus4;
         r_inst     <= i_inst;
         r_valid    <= 1'b1;
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_inst     = r_inst;
   assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC mux, boot/run/stall FSM and IF/ID register (FETCH_PERF_CNT_EN adds counters).
// Latency: pc_next_o combinational; instruction at pc_i reaches ifid_* one cycle later.
// Backpressure: stall_i holds PC and IF/ID; branch_taken_i overrides stall and inserts a bubble.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] pc_next_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [INST_W-1:0] imem_inst_i,
   input  logic              stall_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] ifid_pc_o,
   output logic [ADDR_W-1:0] ifid_pc_plus4_o,
   output logic [INST_W-1:0] ifid_inst_o,
   output logic              ifid_valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt_o,
   output logic [31:0]       bubble_cnt_o
`endif
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_target;
   logic              w_load;
   logic              w_bubble;
   logic              w_hold;

   assign w_pc_plus4  = pc_i + ADDR_W'(PC_STEP);
   assign w_target    = {branch_target_i[ADDR_W-1:2], 2'b00};
   assign imem_addr_o = pc_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      pc_next_o   = w_pc_plus4;
      w_load      = 1'b0;
      w_bubble    = 1'b0;
      w_hold      = 1'b0;
      case (r_state)
         S_BOOT: begin
            pc_next_o   = RESET_PC;
            w_hold      = 1'b1;
            w_state_nxt = S_RUN;
         end
         S_RUN, S_STALL: begin
            if (branch_taken_i) begin
               pc_next_o   = w_target;
               w_bubble    = 1'b1;
               w_state_nxt = S_RUN;
            end else if (stall_i) begin
               pc_next_o   = pc_i;
               w_hold      = 1'b1;
               w_state_nxt = S_STALL;
            end else begin
               pc_next_o   = w_pc_plus4;
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            pc_next_o   = RESET_PC;
            w_hold      = 1'b1;
            w_state_nxt = S_BOOT;
         end
      endcase
   end

   ifid_reg #(
      .ADDR_W(ADDR_W),
      .INST_W(INST_W)
   ) u_ifid_reg (
      .i_clk      (clk_i),
      .i_rst_n    (rst_i),
      .i_load     (w_load),
      .i_bubble   (w_bubble),
      .i_hold     (w_hold),
      .i_pc       (pc_i),
      .i_pc_plus4 (w_pc_plus4),
      .i_inst     (imem_inst_i),
      .o_pc       (ifid_pc_o),
      .o_pc_plus4 (ifid_pc_plus4_o),
      .o_inst     (ifid_inst_o),
      .o_valid    (ifid_valid_o)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_bubble_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_fetch_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_load) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (w_bubble) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
         end
      end
   end

   assign fetch_cnt_o  = r_fetch_cnt;
   assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage with an external PC register and combinational imem.
module tb_fetch_stage;
   import cpu_pkg::*;

   typedef struct {
      int          cyc;
      string       name;
      bit          stall;
      bit          br;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [31:0] pcn;
      logic [31:0] ipc;
      logic [31:0] ip4;
      logic [31:0] iinst;
      logic        ival;
      int          st;
      bit          ccnt;
      logic [31:0] fc;
      logic [31:0] bc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [31:0] tgt = '0;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_inst;
   logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;
`endif

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   vec_t sb[$];
   vec_t vs[$];
   event ev_async;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Program counter register outside the fetch stage; imem returns addr ^ C0DE0000.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_reg <= '0;
      else        pc_reg <= pc_next;
   end
   assign imem_inst = imem_addr ^ 32'hC0DE_0000;

   fetch_stage #(
      .ADDR_W(32),
      .INST_W(32),
      .RESET_PC(32'h0)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_n),
      .pc_i            (pc_reg),
      .pc_next_o       (pc_next),
      .imem_addr_o     (imem_addr),
      .imem_inst_i     (imem_inst),
      .stall_i         (stall),
      .branch_taken_i  (br),
      .branch_target_i (tgt),
      .ifid_pc_o       (ifid_pc),
      .ifid_pc_plus4_o (ifid_pc4),
      .ifid_inst_o     (ifid_inst),
      .ifid_valid_o    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o     (fetch_cnt),
      .bubble_cnt_o    (bubble_cnt)
`endif
   );

   function automatic vec_t mk(string n, bit s, bit b, logic [31:0] t, logic [31:0] pc,
                               logic [31:0] pcn, logic [31:0] ipc, logic [31:0] ip4,
                               logic [31:0] iinst, logic iv);
      vec_t v;
      v.cyc = 0; v.name = n; v.stall = s; v.br = b; v.tgt = t;
      v.pc = pc; v.pcn = pcn; v.ipc = ipc; v.ip4 = ip4; v.iinst = iinst; v.ival = iv;
      v.st = -1; v.ccnt = 1'b0; v.fc = '0; v.bc = '0;
      return v;
   endfunction

   task automatic chk(string tag, string field, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      stall = v.stall;
      br    = v.br;
      tgt   = v.tgt;
      v.cyc = cyc;
      sb.push_back(v);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every expectation tagged for the current cycle.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk or ev_async);
         while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
               n_cmp++;
               n_err++;
               $display("FAIL %s.missed: got cycle %0d, expected cycle %0d", e.name, cyc, e.cyc);
            end else begin
               chk(e.name, "imem_addr", imem_addr, e.pc);
               chk(e.name, "pc_next", pc_next, e.pcn);
               chk(e.name, "ifid_pc", ifid_pc, e.ipc);
               chk(e.name, "ifid_pc4", ifid_pc4, e.ip4);
               chk(e.name, "ifid_inst", ifid_inst, e.iinst);
               chk(e.name, "ifid_valid", {31'd0, ifid_valid}, {31'd0, e.ival});
               if (e.st >= 0) chk(e.name, "state", 32'(dut.r_state), 32'(e.st));
`ifdef FETCH_PERF_CNT_EN
               if (e.ccnt) begin
                  chk(e.name, "fetch_cnt", fetch_cnt, e.fc);
                  chk(e.name, "bubble_cnt", bubble_cnt, e.bc);
               end
`endif
            end
         end
      end
   end

   initial begin
      vec_t r;
      //                  name     stl br  tgt            pc             pc_next        ifid_pc        ifid_pc4       ifid_inst      v
      vs.push_back(mk("boot",    0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'h13,        0)); // 0
      vs.push_back(mk("run0",    0, 0, 32'h0,         32'h0,         32'h4,         32'h0,         32'h0,         32'h13,        0)); // 1
      vs.push_back(mk("run4",    0, 0, 32'h0,         32'h4,         32'h8,         32'h0,         32'h4,         32'hC0DE0000,  1)); // 2
      vs.push_back(mk("run8",    0, 0, 32'h0,         32'h8,         32'hC,         32'h4,         32'h8,         32'hC0DE0004,  1)); // 3
      vs.push_back(mk("runC",    0, 0, 32'h0,         32'hC,         32'h10,        32'h8,         32'hC,         32'hC0DE0008,  1)); // 4
      vs.push_back(mk("stall1",  1, 0, 32'h0,         32'h10,        32'h10,        32'hC,         32'h10,        32'hC0DE000C,  1)); // 5
      vs.push_back(mk("stall2",  1, 0, 32'h0,         32'h10,        32'h10,        32'hC,         32'h10,        32'hC0DE000C,  1)); // 6
      vs.push_back(mk("stall3",  1, 0, 32'h0,         32'h10,        32'h10,        32'hC,         32'h10,        32'hC0DE000C,  1)); // 7
      vs.push_back(mk("unstall", 0, 0, 32'h0,         32'h10,        32'h14,        32'hC,         32'h10,        32'hC0DE000C,  1)); // 8
      vs.push_back(mk("run14",   0, 0, 32'h0,         32'h14,        32'h18,        32'h10,        32'h14,        32'hC0DE0010,  1)); // 9
      vs.push_back(mk("run18",   0, 0, 32'h0,         32'h18,        32'h1C,        32'h14,        32'h18,        32'hC0DE0014,  1)); // 10
      vs.push_back(mk("run1C",   0, 0, 32'h0,         32'h1C,        32'h20,        32'h18,        32'h1C,        32'hC0DE0018,  1)); // 11
      vs.push_back(mk("branch",  0, 1, 32'h103,       32'h20,        32'h100,       32'h1C,        32'h20,        32'hC0DE001C,  1)); // 12
      vs.push_back(mk("bubble",  0, 0, 32'h0,         32'h100,       32'h104,       32'h0,         32'h0,         32'h13,        0)); // 13
      vs.push_back(mk("target",  0, 0, 32'h0,         32'h104,       32'h108,       32'h100,       32'h104,       32'hC0DE0100,  1)); // 14
      vs.push_back(mk("stl_br",  1, 1, 32'h40,        32'h108,       32'h40,        32'h104,       32'h108,       32'hC0DE0104,  1)); // 15
      vs.push_back(mk("stl_br+1",0, 0, 32'h0,         32'h40,        32'h44,        32'h0,         32'h0,         32'h13,        0)); // 16
      vs.push_back(mk("stall44", 1, 0, 32'h0,         32'h44,        32'h44,        32'h40,        32'h44,        32'hC0DE0040,  1)); // 17
      vs.push_back(mk("stl_br2", 1, 1, 32'hFFFFFFFE,  32'h44,        32'hFFFFFFFC,  32'h40,        32'h44,        32'hC0DE0040,  1)); // 18
      vs.push_back(mk("wrap",    0, 0, 32'h0,         32'hFFFFFFFC,  32'h0,         32'h0,         32'h0,         32'h13,        0)); // 19
      vs.push_back(mk("wrap+1",  0, 0, 32'h0,         32'h0,         32'h4,         32'hFFFFFFFC,  32'h0,         32'h3F21FFFC,  1)); // 20
      vs.push_back(mk("pre_rst", 0, 0, 32'h0,         32'h4,         32'h8,         32'h0,         32'h4,         32'hC0DE0000,  1)); // 21
      vs[0].st  = int'(S_BOOT);
      vs[1].st  = int'(S_RUN);
      vs[16].st = int'(S_RUN);
      vs[18].st = int'(S_STALL);
      vs[19].st = int'(S_RUN);
      vs[21].ccnt = 1'b1; vs[21].fc = 32'd13; vs[21].bc = 32'd3;

      // Held in reset for a couple of edges before the first check.
      repeat (2) @(posedge clk);
      #1;
      r = mk("reset", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h13, 0);
      r.st = int'(S_BOOT); r.ccnt = 1'b1;
      drive(r);
      rst_n = 1'b1;
      foreach (vs[i]) drive(vs[i]);

      // Asynchronous reset between edges while IF/ID holds pc 4.
      stall = 1'b0; br = 1'b0; tgt = '0;
      #2;
      rst_n = 1'b0;
      #1;
      r = mk("async_rst", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h13, 0);
      r.st = int'(S_BOOT); r.ccnt = 1'b1; r.cyc = cyc;
      sb.push_back(r);
      ->ev_async;
      @(posedge clk);
      #1;
      r.name = "rst_hold";
      drive(r);
      rst_n = 1'b1;
      r = mk("reboot", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h13, 0);
      r.st = int'(S_BOOT); r.ccnt = 1'b1;
      drive(r);
      r = mk("reboot0", 0, 0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h13, 0);
      drive(r);
      r = mk("reboot4", 0, 0, 32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'hC0DE0000, 1);
      r.ccnt = 1'b1; r.fc = 32'd1; r.bc = 32'd0;
      drive(r);

      for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU, wrapped around the program counter register. Each cycle it takes the current PC and the instruction-memory read data and computes the next PC, which feeds back into the PC register. It also owns the IF/ID pipeline register, including stall (hold), flush (bubble insertion) and a boot sequence after reset.

## Interface
Parameters:
- `ADDR_W`, 32, PC / address width
- `INST_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `pc_i`  in  ADDR_W  current PC from program counter register
- `pc_next_o`  out  ADDR_W  next PC to program counter register (combinational)
- `imem_addr_o`  out  ADDR_W  instruction memory address; equals `pc_i`
- `imem_inst_i`  in  INST_W  instruction memory read data (combinational memory)
- `stall_i`  in  1  hazard unit: hold PC and IF/ID
- `branch_taken_i`  in  1  EX-stage redirect request
- `branch_target_i`  in  ADDR_W  redirect address
- `ifid_pc_o`  out  ADDR_W  registered PC of the instruction in ID
- `ifid_pc_plus4_o`  out  ADDR_W  registered PC+4
- `ifid_inst_o`  out  INST_W  registered instruction
- `ifid_valid_o`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- `pc_plus4 = pc_i + 4`, computed modulo 2^ADDR_W (wraps at 32'hFFFF_FFFC to 0).
- The redirect target is `{branch_target_i[ADDR_W-1:2], 2'b00}`.
- FSM states:
  - `S_BOOT` is entered on reset. It lasts 1 cycle.
    - `pc_next_o = RESET_PC`; IF/ID is not loaded; `ifid_valid_o = 0`.
    - Always goes to `S_RUN`.
  - `S_RUN` is the normal state.
    - Goes to `S_STALL` when `stall_i` and not `branch_taken_i`.
  - `S_STALL` holds the pipeline.
    - Goes to `S_RUN` when `!stall_i` or `branch_taken_i`.
- Priority within `S_RUN` and `S_STALL`, highest first:
  1. `branch_taken_i`:
     - `pc_next_o = target`.
     - IF/ID is loaded with a bubble: `valid = 0`, inst = 32'h0000_0013 (NOP), pc and pc_plus4 = 0.
     - Redirect overrides `stall_i` in the same cycle.
  2. `stall_i`:
     - `pc_next_o = pc_i`.
     - All IF/ID registers hold their values, including valid.
  3. Otherwise:
     - `pc_next_o = pc_plus4`.
     - IF/ID loads `{pc_i, pc_plus4, imem_inst_i, 1}`.
- Reset mid-operation: all registers return immediately (asynchronously) to reset values. `S_BOOT` is then re-entered on the first edge after reset is released.

## Timing
- Reset values:
  - `ifid_pc_o = 0`
  - `ifid_pc_plus4_o = 0`
  - `ifid_inst_o = 32'h0000_0013`
  - `ifid_valid_o = 0`
  - state = `S_BOOT`
- `pc_next_o` and `imem_addr_o` are combinational from `pc_i`, `stall_i`, `branch_taken_i`, `branch_target_i` and state. There is no registered path on these outputs.
- Latency: the instruction addressed in cycle n appears on the `ifid_*` outputs in cycle n+1.
- After a redirect in cycle n:
  - IF/ID shows a bubble in cycle n+1.
  - The target instruction appears with `valid = 1` in cycle n+2, unless a stall intervenes.
- A stall lasting k cycles delays the stream by exactly k cycles. No instruction is lost or duplicated.

## Configuration
- `FETCH_PERF_CNT_EN`:
  - When defined, the block adds 32-bit outputs `fetch_cnt_o` and `bubble_cnt_o`.
    - Both reset to 0 and wrap on overflow.
    - `fetch_cnt_o` increments on each IF/ID load with `valid = 1`.
    - `bubble_cnt_o` increments on each cycle where a redirect loads a bubble.
  - When undefined, the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum (`S_BOOT`, `S_RUN`, `S_STALL`)
  - `NOP_INST` = 32'h0000_0013
  - `PC_STEP` = 4
- One sub-module, `ifid_reg`: the IF/ID pipeline register.
  - Inputs: load, bubble and hold controls, plus asynchronous active-low reset.
  - Holds the four IF/ID fields.
- The FSM and next-PC mux live in `fetch_stage`.

## Test plan
- Reset released with PC register at `RESET_PC` = 0:
  - Boot cycle: `pc_next_o = 0`, `ifid_valid_o = 0`.
  - Next cycles: `pc_next_o` = 4, 8, 12.
  - IF/ID shows pc 0 with `imem_inst_i` from address 0, `valid = 1`.
- `stall_i` high for 3 cycles at pc = 0x10:
  - `pc_next_o` stays 0x10.
  - IF/ID holds pc 0x0C throughout.
  - After release, pc 0x10 enters IF/ID exactly once.
- `branch_taken_i` with target 0x103 at pc = 0x20:
  - `pc_next_o = 0x100`.
  - Next cycle: `ifid_valid_o = 0`, inst = NOP.
  - Cycle after: `ifid_pc_o = 0x100`, `valid = 1`.
- `stall_i` and `branch_taken_i` both high:
  - Redirect wins: `pc_next_o = target`, IF/ID gets a bubble, state = `S_RUN`.
- Wrap: pc = 0xFFFF_FFFC, no stall or branch:
  - `pc_next_o = 0`.
  - `ifid_pc_plus4_o = 0` next cycle.
- `rst_i` pulled low between clock edges while IF/ID is valid:
  - Outputs drop to reset values immediately, without waiting for a clock edge.
  - After release, the boot sequence repeats.
  - With `FETCH_PERF_CNT_EN` defined, both counters read 0.
